pll_loop_filter_rw: RTL and testbench

// - Parametrised random-walk loop filter for the digital PLL, between the phase detector and the DCO/phase shifter.
// - Integrates forwarding/slowing votes in a signed counter and emits a one-cycle shift pulse when a programmable threshold is reached.
// - Adds a selectable second-order (frequency-tracking) mode and a post-shift hold-off, which the first-generation filter lacks.

---
 rtl/pll_pkg.sv | 10 +
 rtl/pll_rate_tick.sv | 24 ++
 rtl/pll_loop_filter_rw.sv | 112 +++++++++++
 tb/tb_pll_loop_filter_rw.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and defaults for the digital PLL loop-filter blocks.
package pll_pkg;

    typedef enum logic {FIRST_ORDER, SECOND_ORDER} lf_mode_e;

    typedef enum logic [1:0] {SHIFT_NONE, SHIFT_POS, SHIFT_NEG} shift_dir_e;

    localparam int LF_CNT_W_DEF = 8;

endpackage

// File: rtl/pll_rate_tick.sv
// Free-running divider: one tick every 2**RATE_SH enabled cycles, on the wrap cycle.
module pll_rate_tick #(
    parameter int RATE_SH = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o
);

    if (RATE_SH == 0) begin : g_none
        assign tick_o = en_i;
    end else begin : g_div
        logic [RATE_SH-1:0] div_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)   div_q <= '0;
            else if (en_i) div_q <= div_q + 1'b1;
        end

        assign tick_o = en_i && (div_q == '1);
    end

endmodule

// File: rtl/pll_loop_filter_rw.sv
// Random-walk PLL loop filter with optional frequency-tracking integral and post-shift hold-off.
module pll_loop_filter_rw
    import pll_pkg::*;
#(
    parameter int CNT_W   = LF_CNT_W_DEF,
    parameter int INT_W   = 6,
    parameter int RATE_SH = 4,
    parameter int HOLDOFF = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    mode_i,
    input  logic [CNT_W-2:0]        threshold_i,
    input  logic                    forwarding_i,
    input  logic                    slowing_i,
    output logic                    positiveShift_o,
    output logic                    negativeShift_o,
    output logic signed [CNT_W-1:0] count_o,
    output logic signed [INT_W-1:0] integral_o,
    output logic                    sat_o
);

    localparam int N_W  = CNT_W + 1;
    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    logic signed [CNT_W-1:0] count_q, count_d;
    logic signed [INT_W-1:0] integral_q, integral_d;
    logic [HO_W-1:0]         hold_q, hold_d;
    logic [CNT_W-2:0]        k_q, k_d, k_sel;
    logic                    pos_q, pos_d, neg_q, neg_d;
    logic                    tick;
    lf_mode_e                mode;
    shift_dir_e              dir;
    logic signed [N_W-1:0]   vote, inj, n, keff;

    assign mode = mode_i ? SECOND_ORDER : FIRST_ORDER;

    pll_rate_tick #(.RATE_SH(RATE_SH)) u_tick (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (enable_i),
        .tick_o (tick)
    );

    always_comb begin
        vote = '0;
        if (forwarding_i && !slowing_i)      vote = N_W'(1);
        else if (slowing_i && !forwarding_i) vote = N_W'(-1);

        inj = (mode == SECOND_ORDER && tick) ? N_W'(integral_q) : '0;
        n   = N_W'(count_q) + vote + inj;

        // The trip level only follows threshold_i while the walk is parked at zero.
        k_sel = (count_q == '0) ? threshold_i : k_q;
        k_d   = k_sel;
        keff  = (k_sel == '0) ? N_W'(1) : N_W'($signed({1'b0, k_sel}));

        dir = SHIFT_NONE;
        if (enable_i && hold_q == '0) begin
            if (n >= keff)       dir = SHIFT_POS;
            else if (n <= -keff) dir = SHIFT_NEG;
        end

        pos_d      = (dir == SHIFT_POS);
        neg_d      = (dir == SHIFT_NEG);
        hold_d     = (hold_q != '0) ? hold_q - 1'b1 : '0;
        count_d    = count_q;
        integral_d = integral_q;

        if (dir != SHIFT_NONE) begin
            count_d = '0;
            hold_d  = HO_W'(HOLDOFF);
            if (mode == SECOND_ORDER) begin
                if (dir == SHIFT_POS && integral_q != INT_MAX) integral_d = integral_q + INT_W'(1);
                if (dir == SHIFT_NEG && integral_q != INT_MIN) integral_d = integral_q - INT_W'(1);
            end
        end else if (enable_i) begin
            // Outside hold-off n is already inside the band, so the clamp only bites during hold-off.
            if (n > keff)       count_d = CNT_W'(keff);
            else if (n < -keff) count_d = CNT_W'(-keff);
            else                count_d = CNT_W'(n);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q    <= '0;
            integral_q <= '0;
            hold_q     <= '0;
            k_q        <= '0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            integral_q <= integral_d;
            hold_q     <= hold_d;
            k_q        <= k_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
        end
    end

    assign positiveShift_o = pos_q;
    assign negativeShift_o = neg_q;
    assign count_o         = count_q;
    assign integral_o      = integral_q;
    assign sat_o           = (integral_q == INT_MAX) || (integral_q == INT_MIN);

endmodule

// File: tb/tb_pll_loop_filter_rw.sv
// Directed scenarios plus randomized walk, checked every cycle against an integer model of the filter.
module tb_pll_loop_filter_rw;

    localparam int CNT_W   = 8;
    localparam int INT_W   = 6;
    localparam int RATE_SH = 4;
    localparam int HOLDOFF = 4;
    localparam int IMAX    = 31;
    localparam int IMIN    = -32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b0, mode = 1'b0, fw = 1'b0, sl = 1'b0;
    logic [CNT_W-2:0]        thr = '0;
    logic                    pos, neg, sat;
    logic signed [CNT_W-1:0] cnt;
    logic signed [INT_W-1:0] integ;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 0;
    int m_cnt, m_int, m_div, m_hold, m_k;
    bit e_pos, e_neg;

    pll_loop_filter_rw #(.CNT_W(CNT_W), .INT_W(INT_W), .RATE_SH(RATE_SH), .HOLDOFF(HOLDOFF)) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .mode_i(mode), .threshold_i(thr),
        .forwarding_i(fw), .slowing_i(sl), .positiveShift_o(pos), .negativeShift_o(neg),
        .count_o(cnt), .integral_o(integ), .sat_o(sat)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock of the filter described in plain integer arithmetic.
    task automatic model_step();
        int k, ke, v, inj, n;
        bit fp, fn;
        fp = 0; fn = 0;
        if (rst) begin
            m_cnt = 0; m_int = 0; m_div = 0; m_hold = 0; m_k = 0;
        end else begin
            k   = (m_cnt == 0) ? int'(thr) : m_k;
            m_k = k;
            ke  = (k < 1) ? 1 : k;
            if (en) begin
                v     = (fw && !sl) ? 1 : ((sl && !fw) ? -1 : 0);
                m_div = (m_div + 1) % (1 << RATE_SH);
                inj   = (mode && m_div == 0) ? m_int : 0;
                n     = m_cnt + v + inj;
                if (m_hold == 0 && n >= ke)       fp = 1;
                else if (m_hold == 0 && n <= -ke) fn = 1;
                if (fp || fn) m_cnt = 0;
                else          m_cnt = (n > ke) ? ke : ((n < -ke) ? -ke : n);
                if (mode && fp) m_int = (m_int < IMAX) ? m_int + 1 : IMAX;
                if (mode && fn) m_int = (m_int > IMIN) ? m_int - 1 : IMIN;
            end
            m_hold = (fp || fn) ? HOLDOFF : ((m_hold > 0) ? m_hold - 1 : 0);
        end
        e_pos = fp; e_neg = fn;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (chk_on) begin
            check("pos", int'(pos), int'(e_pos));
            check("neg", int'(neg), int'(e_neg));
            check("count", int'(cnt), m_cnt);
            check("integral", int'(integ), m_int);
            check("sat", int'(sat), int'(m_int == IMAX || m_int == IMIN));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; fw = 0; sl = 0; mode = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int pulses, mx, mn, fires, hit;

        @(negedge clk);
        check("rst_count", int'(cnt), 0);
        check("rst_integral", int'(integ), 0);
        check("rst_pulses", int'(pos) + int'(neg) + int'(sat), 0);
        rst = 0;
        chk_on = 1;

        // K=8 first order, forwarding held
        thr = 8; en = 1; fw = 1;
        pulses = 0; mx = -999;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pos) pulses++;
            if (int'(cnt) > mx) mx = int'(cnt);
            if (i == 2) check("t1_count3", int'(cnt), 3);
        end
        check("t1_pulses", pulses, 8);
        check("t1_max", mx, 7);

        // conflicting votes
        do_reset();
        en = 1; fw = 1; sl = 1; thr = 8;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pulses += int'(pos) + int'(neg);
        end
        check("t2_pulses", pulses, 0);
        check("t2_count", int'(cnt), 0);

        // K=2 with hold-off clamp
        do_reset();
        en = 1; sl = 1; thr = 2;
        pulses = 0; mn = 999;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (neg) pulses++;
            if (int'(cnt) < mn) mn = int'(cnt);
        end
        check("t3_pulses", pulses, 6);
        check("t3_min", mn, -2);

        // second order saturation, then injection-only firing
        do_reset();
        en = 1; mode = 1; fw = 1; thr = 8;
        fires = 0;
        for (int i = 0; i < 3000 && fires < 40; i++) begin
            @(negedge clk);
            if (pos) fires++;
        end
        check("t4_fires", fires, 40);
        check("t4_integral", int'(integ), 31);
        check("t4_sat", int'(sat), 1);
        fw = 0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (pos) hit = 1;
        end
        check("t4_first_inj", hit, 1);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pos) pulses++;
        end
        check("t4_inj_pulses", pulses, 4);

        // threshold change mid-walk
        do_reset();
        en = 1; fw = 1; thr = 8;
        repeat (5) @(negedge clk);
        check("t5_count5", int'(cnt), 5);
        thr = 3;
        @(negedge clk); check("t5_obs1", int'(pos), 0);
        @(negedge clk); check("t5_obs2", int'(pos), 0);
        @(negedge clk); check("t5_obs3", int'(pos), 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pos) pulses++;
        end
        check("t5_k3_pulses", pulses, 4);

        // asynchronous reset mid-walk
        do_reset();
        en = 1; mode = 1; fw = 1; thr = 2;
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (int'(integ) == 4) hit = 1;
        end
        check("t6_reach_int4", hit, 1);
        mode = 0; thr = 8;
        repeat (6) @(negedge clk);
        check("t6_count6", int'(cnt), 6);
        check("t6_int4", int'(integ), 4);
        #2 rst = 1;
        #1;
        check("t6_async_count", int'(cnt), 0);
        check("t6_async_integral", int'(integ), 0);
        check("t6_async_flags", int'(pos) + int'(neg) + int'(sat), 0);
        @(negedge clk);
        rst = 0;

        // randomized walk
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            @(negedge clk);
            if (i % 40 == 0) begin
                mode = 1'($urandom_range(0, 1));
                thr  = 7'($urandom_range(0, 12));
            end
            en = ($urandom_range(0, 9) != 0);
            fw = ($urandom_range(0, 9) < 6);
            sl = ($urandom_range(0, 9) < ((i % 400 < 200) ? 3 : 8));
        end

        @(negedge clk);
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
